// File: rtl/e203_soc_aon_shell.sv
// Always-on / pad-control shell for the E203 SoC.
// Divides clk into the low-frequency clock, synchronizes the external reset,
// sequences PMU sleep/wake, decodes boot/debug straps and owns the GPIO pad
// registers plus the RTC through a simple word-indexed register port.
// Optional build macro GPIO_B_EN: when defined, bank B mirrors bank A;
// otherwise bank B outputs are tied low and its addresses read zero.
module e203_soc_aon_shell #(
  parameter int unsigned LF_DIV_LOG2    = 6,
  parameter logic [31:0] ROM_BOOT_ADDR  = 32'h0000_1000,
  parameter logic [31:0] ITCM_BOOT_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        lfclk_o,
  output logic        core_rst_n_o,
  input  logic        pmu_dwakeup_n_i,
  output logic        pmu_vddpaden_o,
  output logic        pmu_padrst_o,
  input  logic        bootrom_n_i,
  input  logic [2:0]  dbgmode_n_i,
  output logic [2:0]  dbgmode_o,
  output logic [31:0] reset_vector_o,
  input  logic        reg_wr,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  logic [31:0] gpioA_i,
  output logic [31:0] gpioA_o,
  output logic [31:0] gpioA_oe,
  input  logic [31:0] gpioB_i,
  output logic [31:0] gpioB_o,
  output logic [31:0] gpioB_oe
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StSleep = 2'd1,
    StWake  = 2'd2
  } pmu_state_e;

  // Counter value on the cycle before the MSB goes high.
  localparam logic [LF_DIV_LOG2-1:0] LfRiseCnt = LF_DIV_LOG2'((1 << (LF_DIV_LOG2 - 1)) - 1);

  logic [LF_DIV_LOG2-1:0] lf_cnt_q;
  logic [1:0]             rst_sync_q;
  pmu_state_e             pmu_state_q;
  logic                   wake_cnt_q;
  logic                   pmu_run_q;
  logic                   vddpaden_q;
  logic [31:0]            a_out_q, a_oe_q, a_in_s1_q, a_in_s2_q;
  logic [31:0]            rtc_q;
  logic                   lf_rise;
  logic                   sleep_req;

  assign lf_rise   = (lf_cnt_q == LfRiseCnt);
  assign sleep_req = reg_wr && (reg_addr == 4'd7) && reg_wdata[0];

  assign lfclk_o        = lf_cnt_q[LF_DIV_LOG2-1];
  assign core_rst_n_o   = rst_sync_q[1] & pmu_run_q;
  assign pmu_padrst_o   = ~core_rst_n_o;
  assign pmu_vddpaden_o = vddpaden_q;
  assign dbgmode_o      = ~dbgmode_n_i;
  assign reset_vector_o = bootrom_n_i ? ITCM_BOOT_ADDR : ROM_BOOT_ADDR;
  assign gpioA_o        = a_out_q;
  assign gpioA_oe       = a_oe_q;

  // Free-running divider; its MSB is the low-frequency clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lf_cnt_q <= '0;
    else        lf_cnt_q <= lf_cnt_q + LF_DIV_LOG2'(1);
  end

  // Reset synchronizer: asynchronous assert, release after two clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // PMU sequencer with registered pad-power and core-run controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmu_state_q <= StRun;
      wake_cnt_q  <= 1'b0;
      pmu_run_q   <= 1'b1;
      vddpaden_q  <= 1'b1;
    end else begin
      unique case (pmu_state_q)
        StRun: begin
          if (sleep_req) begin
            pmu_state_q <= StSleep;
            pmu_run_q   <= 1'b0;
            vddpaden_q  <= 1'b0;
          end
        end
        StSleep: begin
          if (!pmu_dwakeup_n_i) begin
            pmu_state_q <= StWake;
            wake_cnt_q  <= 1'b0;
            vddpaden_q  <= 1'b1;
          end
        end
        StWake: begin
          // Hold the core in reset for two full cycles after power returns.
          if (wake_cnt_q) begin
            pmu_state_q <= StRun;
            pmu_run_q   <= 1'b1;
          end else begin
            wake_cnt_q <= 1'b1;
          end
        end
        default: begin
          pmu_state_q <= StRun;
          pmu_run_q   <= 1'b1;
          vddpaden_q  <= 1'b1;
        end
      endcase
    end
  end

  // GPIO bank A output/enable registers and input synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out_q   <= '0;
      a_oe_q    <= '0;
      a_in_s1_q <= '0;
      a_in_s2_q <= '0;
    end else begin
      if (reg_wr && reg_addr == 4'd0) a_out_q <= reg_wdata;
      if (reg_wr && reg_addr == 4'd1) a_oe_q  <= reg_wdata;
      a_in_s1_q <= gpioA_i;
      a_in_s2_q <= a_in_s1_q;
    end
  end

`ifdef GPIO_B_EN
  logic [31:0] b_out_q, b_oe_q, b_in_s1_q, b_in_s2_q;

  assign gpioB_o  = b_out_q;
  assign gpioB_oe = b_oe_q;

  // GPIO bank B, identical to bank A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_out_q   <= '0;
      b_oe_q    <= '0;
      b_in_s1_q <= '0;
      b_in_s2_q <= '0;
    end else begin
      if (reg_wr && reg_addr == 4'd3) b_out_q <= reg_wdata;
      if (reg_wr && reg_addr == 4'd4) b_oe_q  <= reg_wdata;
      b_in_s1_q <= gpioB_i;
      b_in_s2_q <= b_in_s1_q;
    end
  end
`else
  logic unused_gpiob;

  assign gpioB_o     = '0;
  assign gpioB_oe    = '0;
  assign unused_gpiob = ^gpioB_i;
`endif

  // RTC ticks on each lfclk rise; a register write takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         rtc_q <= '0;
    else if (reg_wr && reg_addr == 4'd6) rtc_q <= reg_wdata;
    else if (lf_rise)                   rtc_q <= rtc_q + 32'd1;
  end

  // Combinational read mux; unmapped indices return zero.
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      4'd0: reg_rdata = a_out_q;
      4'd1: reg_rdata = a_oe_q;
      4'd2: reg_rdata = a_in_s2_q;
`ifdef GPIO_B_EN
      4'd3: reg_rdata = b_out_q;
      4'd4: reg_rdata = b_oe_q;
      4'd5: reg_rdata = b_in_s2_q;
`endif
      4'd6: reg_rdata = rtc_q;
      4'd7: reg_rdata = {29'b0, pmu_state_q, 1'b0};
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_e203_soc_aon_shell.sv
// Self-checking bench for e203_soc_aon_shell: reset release, divider, RTC,
// straps and GPIO via a vector table, plus PMU and mid-operation reset sequences.
module tb_e203_soc_aon_shell;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lfclk_o, core_rst_n_o, pmu_dwakeup_n_i, pmu_vddpaden_o, pmu_padrst_o;
  logic        bootrom_n_i;
  logic [2:0]  dbgmode_n_i, dbgmode_o;
  logic [31:0] reset_vector_o;
  logic        reg_wr;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [31:0] gpioA_i, gpioA_o, gpioA_oe, gpioB_i, gpioB_o, gpioB_oe;

  int n_cmp = 0;
  int n_err = 0;
  int edges = 0;

`ifdef GPIO_B_EN
  localparam logic [31:0] BWr = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] BWr = 32'h0;
`endif

  e203_soc_aon_shell dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lfclk_o         (lfclk_o),
    .core_rst_n_o    (core_rst_n_o),
    .pmu_dwakeup_n_i (pmu_dwakeup_n_i),
    .pmu_vddpaden_o  (pmu_vddpaden_o),
    .pmu_padrst_o    (pmu_padrst_o),
    .bootrom_n_i     (bootrom_n_i),
    .dbgmode_n_i     (dbgmode_n_i),
    .dbgmode_o       (dbgmode_o),
    .reset_vector_o  (reset_vector_o),
    .reg_wr          (reg_wr),
    .reg_addr        (reg_addr),
    .reg_wdata       (reg_wdata),
    .reg_rdata       (reg_rdata),
    .gpioA_i         (gpioA_i),
    .gpioA_o         (gpioA_o),
    .gpioA_oe        (gpioA_oe),
    .gpioB_i         (gpioB_i),
    .gpioB_o         (gpioB_o),
    .gpioB_oe        (gpioB_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] ga_i;
    logic        boot_n;
    logic [2:0]  dbg_n;
    logic [31:0] exp_rdata;
    logic [31:0] exp_ga_o;
    logic [31:0] exp_ga_oe;
    logic [31:0] exp_gb_o;
    logic [31:0] exp_vec;
    logic [2:0]  exp_dbg;
    logic        exp_vdd;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clk edge; outputs are sampled on the following falling edge.
  task automatic cyc();
    @(negedge clk);
    edges++;
  endtask

  task automatic run_to(input int e);
    while (edges < e) cyc();
  endtask

  task automatic wait_mod(input int m);
    for (int k = 0; k < 64 && (edges % 64) != m; k++) cyc();
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_wr    = 1'b1;
    cyc();
    reg_wr    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pmu_dwakeup_n_i = 1'b1; bootrom_n_i = 1'b0; dbgmode_n_i = 3'b111;
    reg_wr = 1'b0; reg_addr = 4'd0; reg_wdata = '0; gpioA_i = '0; gpioB_i = '0;

    // Vector table: each row is applied for one clk edge, then checked.
    tbl[0] = '{1'b1, 4'd0,  32'hA5A5_0000, 32'h0,         1'b0, 3'b110,
               32'hA5A5_0000, 32'hA5A5_0000, 32'h0, 32'h0, 32'h0000_1000, 3'b001, 1'b1};
    tbl[1] = '{1'b0, 4'd2,  32'h0,         32'h1234_5678, 1'b1, 3'b111,
               32'h0,         32'hA5A5_0000, 32'h0, 32'h0, 32'h8000_0000, 3'b000, 1'b1};
    tbl[2] = '{1'b0, 4'd2,  32'h0,         32'h1234_5678, 1'b0, 3'b000,
               32'h1234_5678, 32'hA5A5_0000, 32'h0, 32'h0, 32'h0000_1000, 3'b111, 1'b1};
    tbl[3] = '{1'b1, 4'd1,  32'hFFFF_0000, 32'h1234_5678, 1'b0, 3'b101,
               32'hFFFF_0000, 32'hA5A5_0000, 32'hFFFF_0000, 32'h0, 32'h0000_1000, 3'b010, 1'b1};
    tbl[4] = '{1'b1, 4'd3,  32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 3'b011,
               BWr,           32'hA5A5_0000, 32'hFFFF_0000, BWr, 32'h8000_0000, 3'b100, 1'b1};
    tbl[5] = '{1'b1, 4'd8,  32'h0000_0055, 32'h1234_5678, 1'b1, 3'b111,
               32'h0,         32'hA5A5_0000, 32'hFFFF_0000, BWr, 32'h8000_0000, 3'b000, 1'b1};
    tbl[6] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 3'b111,
               32'h0,         32'hA5A5_0000, 32'hFFFF_0000, BWr, 32'h8000_0000, 3'b000, 1'b1};
    tbl[7] = '{1'b0, 4'd0,  32'h0,         32'h1234_5678, 1'b0, 3'b111,
               32'hA5A5_0000, 32'hA5A5_0000, 32'hFFFF_0000, BWr, 32'h0000_1000, 3'b000, 1'b1};
    tbl[8] = '{1'b0, 4'd5,  32'h0,         32'h1234_5678, 1'b0, 3'b111,
               32'h0,         32'hA5A5_0000, 32'hFFFF_0000, BWr, 32'h0000_1000, 3'b000, 1'b1};
    tbl[9] = '{1'b1, 4'd7,  32'h0000_0002, 32'h1234_5678, 1'b0, 3'b111,
               32'h0,         32'hA5A5_0000, 32'hFFFF_0000, BWr, 32'h0000_1000, 3'b000, 1'b1};

    // Reset state.
    repeat (5) @(negedge clk);
    chk("rst core_rst_n", core_rst_n_o, 1'b0);
    chk("rst padrst", pmu_padrst_o, 1'b1);
    chk("rst vddpaden", pmu_vddpaden_o, 1'b1);
    chk("rst lfclk", lfclk_o, 1'b0);
    chk("rst gpioA_o", gpioA_o, 32'h0);
    chk("rst gpioA_oe", gpioA_oe, 32'h0);
    chk("rst rdata0", reg_rdata, 32'h0);

    // Release and check synchronizer / divider timing.
    rst_n = 1'b1;
    edges = 0;
    cyc();
    chk("core_rst_n edge1", core_rst_n_o, 1'b0);
    cyc();
    chk("core_rst_n edge2", core_rst_n_o, 1'b1);
    chk("padrst edge2", pmu_padrst_o, 1'b0);
    run_to(31); chk("lfclk edge31", lfclk_o, 1'b0);
    run_to(32); chk("lfclk edge32", lfclk_o, 1'b1);
    run_to(63); chk("lfclk edge63", lfclk_o, 1'b1);
    run_to(64); chk("lfclk edge64", lfclk_o, 1'b0);
    run_to(96); chk("lfclk edge96", lfclk_o, 1'b1);
    reg_addr = 4'd6;
    run_to(607); chk("rtc edge607", reg_rdata, 32'd9);
    run_to(608); chk("rtc edge608", reg_rdata, 32'd10);
    run_to(640); chk("rtc edge640", reg_rdata, 32'd10);

    // Table-driven register, GPIO and strap vectors.
    for (int i = 0; i < 10; i++) begin
      reg_wr = tbl[i].wr; reg_addr = tbl[i].addr; reg_wdata = tbl[i].wdata;
      gpioA_i = tbl[i].ga_i; bootrom_n_i = tbl[i].boot_n; dbgmode_n_i = tbl[i].dbg_n;
      cyc();
      reg_wr = 1'b0;
      chk($sformatf("vec%0d rdata", i), reg_rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d gpioA_o", i), gpioA_o, tbl[i].exp_ga_o);
      chk($sformatf("vec%0d gpioA_oe", i), gpioA_oe, tbl[i].exp_ga_oe);
      chk($sformatf("vec%0d gpioB_o", i), gpioB_o, tbl[i].exp_gb_o);
      chk($sformatf("vec%0d reset_vector", i), reset_vector_o, tbl[i].exp_vec);
      chk($sformatf("vec%0d dbgmode", i), {29'b0, dbgmode_o}, {29'b0, tbl[i].exp_dbg});
      chk($sformatf("vec%0d vddpaden", i), pmu_vddpaden_o, tbl[i].exp_vdd);
    end
    chk("gpioB_oe", gpioB_oe, 32'h0);

    // RTC: write on a non-rise cycle, then wrap at the next rise.
    wait_mod(40);
    reg_write(4'd6, 32'hFFFF_FFFF);
    chk("rtc write", reg_rdata, 32'hFFFF_FFFF);
    wait_mod(31);
    chk("rtc hold pre-rise", reg_rdata, 32'hFFFF_FFFF);
    cyc();
    chk("rtc wrap", reg_rdata, 32'h0);
    // Write coinciding with a rise wins over the increment.
    wait_mod(31);
    reg_write(4'd6, 32'h1234_0000);
    chk("rtc write on rise", reg_rdata, 32'h1234_0000);
    cyc();
    wait_mod(32);
    chk("rtc next rise", reg_rdata, 32'h1234_0001);

    // PMU sleep entry.
    reg_write(4'd7, 32'h1);
    chk("sleep vddpaden", pmu_vddpaden_o, 1'b0);
    chk("sleep padrst", pmu_padrst_o, 1'b1);
    chk("sleep core_rst_n", core_rst_n_o, 1'b0);
    chk("sleep state", reg_rdata, 32'h2);
    reg_write(4'd7, 32'h1);
    chk("sleep rewrite state", reg_rdata, 32'h2);
    reg_write(4'd0, 32'h0F0F_0F0F);
    chk("sleep gpio write", gpioA_o, 32'h0F0F_0F0F);
    reg_addr = 4'd7;
    cyc();
    chk("sleep hold", reg_rdata, 32'h2);
    // Wake pulse: two cycles in WAKE, then RUN.
    pmu_dwakeup_n_i = 1'b0;
    cyc();
    pmu_dwakeup_n_i = 1'b1;
    chk("wake1 state", reg_rdata, 32'h4);
    chk("wake1 vddpaden", pmu_vddpaden_o, 1'b1);
    chk("wake1 core_rst_n", core_rst_n_o, 1'b0);
    cyc();
    chk("wake2 state", reg_rdata, 32'h4);
    chk("wake2 core_rst_n", core_rst_n_o, 1'b0);
    cyc();
    chk("run state", reg_rdata, 32'h0);
    chk("run core_rst_n", core_rst_n_o, 1'b1);
    chk("run padrst", pmu_padrst_o, 1'b0);
    // Wake pad ignored while running.
    pmu_dwakeup_n_i = 1'b0;
    cyc(); cyc();
    pmu_dwakeup_n_i = 1'b1;
    chk("run ignores wake", reg_rdata, 32'h0);
    chk("run ignores wake core", core_rst_n_o, 1'b1);

    // Mid-operation reset while sleeping.
    reg_write(4'd7, 32'h1);
    chk("sleep2 state", reg_rdata, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mid rst state", reg_rdata, 32'h0);
    chk("mid rst core_rst_n", core_rst_n_o, 1'b0);
    chk("mid rst vddpaden", pmu_vddpaden_o, 1'b1);
    chk("mid rst gpioA_o", gpioA_o, 32'h0);
    chk("mid rst gpioA_oe", gpioA_oe, 32'h0);
    chk("mid rst lfclk", lfclk_o, 1'b0);
    reg_addr = 4'd6;
    #1;
    chk("mid rst rtc", reg_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    cyc();
    chk("re-release edge1", core_rst_n_o, 1'b0);
    cyc();
    chk("re-release edge2", core_rst_n_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/e203_soc_aon_shell.md
Name: e203_soc_aon_shell

Overview:
- Always-on and pad-control shell at the top of the E203 SoC, between chip pads and the core subsystem.
- Generates the low-frequency clock from the high-frequency clock and sequences core reset and PMU sleep/wake.
- Decodes boot and debug-mode straps and owns the GPIO pad registers through a simple register port driven by the subsystem.

Parameters:
- LF_DIV_LOG2, 6, low-frequency clock = clk / 2^LF_DIV_LOG2.
- ROM_BOOT_ADDR, 32'h0000_1000, reset vector when booting from ROM.
- ITCM_BOOT_ADDR, 32'h8000_0000, reset vector when booting from ITCM.

Ports:
- clk  in  1  high-frequency clock (hfextclk)
- rst_n  in  1  asynchronous active-low external reset (aon_erst_n)
- lfclk_o  out  1  divided low-frequency clock
- core_rst_n_o  out  1  reset to core subsystem, active low
- pmu_dwakeup_n_i  in  1  wake pad, active low
- pmu_vddpaden_o  out  1  pad power enable
- pmu_padrst_o  out  1  pad reset, high while core is held in reset
- bootrom_n_i  in  1  boot strap, 0 = ROM
- dbgmode_n_i  in  3  debug-mode straps, active low
- dbgmode_o  out  3  decoded debug mode
- reset_vector_o  out  32  core reset PC
- reg_wr  in  1  register write strobe
- reg_addr  in  4  word register index
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, combinational
- gpioA_i  in  32  GPIO A pad inputs
- gpioA_o  out  32  GPIO A outputs
- gpioA_oe  out  32  GPIO A output enables
- gpioB_i  in  32  GPIO B pad inputs
- gpioB_o  out  32  GPIO B outputs
- gpioB_oe  out  32  GPIO B output enables

Behaviour:
- Reset and clocking: clk is the only clock. rst_n is asynchronous, active-low; all flops clear on it.
- lfclk divider:
  - LF_DIV_LOG2-bit counter increments every clk cycle and wraps.
  - lfclk_o = counter MSB: low for the first 32 cycles after reset, then period 64.
- Reset synchronizer:
  - Two-flop synchronizer on rst_n. Assertion is asynchronous.
  - After rst_n deasserts, core_rst_n_o rises on the 2nd clk edge if the PMU is in RUN.
- Straps:
  - dbgmode_o = ~dbgmode_n_i, continuous.
  - reset_vector_o = bootrom_n_i ? ITCM_BOOT_ADDR : ROM_BOOT_ADDR, continuous.
- PMU FSM states:
  - RUN (reset state): vddpaden=1; core_rst_n follows the synchronizer.
  - SLEEP: entered on a write of 1 to PMU_CTRL bit0 while in RUN. vddpaden=0, core_rst_n=0.
  - WAKE: entered from SLEEP when pmu_dwakeup_n_i is sampled low. vddpaden=1, core_rst_n=0 for exactly 2 cycles, then RUN.
  - pmu_padrst_o = ~core_rst_n_o in all states.
  - During SLEEP, further writes to PMU_CTRL have no effect; pmu_dwakeup_n_i is ignored in RUN.
- Registers (reg_addr); unmapped addresses read 0 and ignore writes:
  - 0 GPIOA_OUT: rw, reset 0.
  - 1 GPIOA_OE: rw, reset 0.
  - 2 GPIOA_IN: ro; gpioA_i through a 2-flop synchronizer, 2-cycle latency.
  - 3/4/5 GPIOB_OUT/OE/IN: same as A (see optional feature).
  - 6 RTC:
    - 32-bit counter, reset 0; increments on the cycle lfclk_o rises.
    - Wraps 0xFFFF_FFFF to 0.
    - A write loads reg_wdata; if a write and an increment coincide, the write wins.
  - 7 PMU_CTRL: write bit0=1 requests sleep; reads {29'b0, state[1:0], 1'b0} with RUN=0, SLEEP=1, WAKE=2.
- Register writes take effect on the clk edge where reg_wr=1, in any PMU state.
- gpioX_o and gpioX_oe are register outputs, so new values appear the cycle after the write.

Optional Feature:
- GPIO_B_EN defined: bank B is implemented exactly as bank A.
- GPIO_B_EN undefined:
  - gpioB_o and gpioB_oe are tied to 0.
  - Addresses 3-5 read 0 and ignore writes; gpioB_i is unused.

Test Plan:
- Reset release: rst_n low 5 cycles, then high -> core_rst_n_o=0 until the 2nd edge then 1; lfclk_o=0 for 32 cycles, rises at cycle 32, period 64.
- Straps: bootrom_n_i=0 -> reset_vector_o=0x0000_1000; =1 -> 0x8000_0000. dbgmode_n_i=3'b110 -> dbgmode_o=3'b001.
- GPIO: write GPIOA_OUT=0xA5A5_0000 and GPIOA_OE=0xFFFF_0000 -> pins update next cycle. Drive gpioA_i=0x1234_5678 -> GPIOA_IN reads it after 2 cycles.
- RTC: after 640 cycles from reset, RTC=10. Write 0xFFFF_FFFF on a non-rising cycle -> wraps to 0 at the next lfclk rise. A write coinciding with an lfclk rise loads the written value exactly.
- PMU: write PMU_CTRL=1 -> next cycle vddpaden=0, padrst=1, state reads 1. Pulse dwakeup_n low -> WAKE for 2 cycles, then core_rst_n_o=1 and state=0.
- Mid-operation reset: assert rst_n during SLEEP -> all registers 0, state RUN, outputs at reset values.
